dual_debounce: RTL

Two-channel input conditioner that sits directly upstream of `and_gate`. It takes raw, possibly bouncing `in1`/`in2` levels from switches or external pins and produces clean, glitch-free levels `out1`/`out2` that feed `and_gate`'s `in1`/`in2`. Each channel runs an independent synchronizer, stability counter and four-state FSM, and flags each accepted transition with a one-cycle edge pulse.

---
 rtl/dual_debounce.sv | 105 ++++++++++
 1 files changed

// File: rtl/dual_debounce.sv
// dual_debounce: two-channel switch debouncer with edge pulses; define DEBOUNCE_SYNC_EN to add a 2-flop input synchronizer
module dual_debounce #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic in1,
  input  logic in2,
  output logic out1,
  output logic out2,
  output logic rise1,
  output logic rise2,
  output logic fall1,
  output logic fall2
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam bit ONE = STABLE_CYCLES == 1;
  logic [1:0] in_v, out_v, rise_v, fall_v;
  assign in_v  = {in2, in1};
  assign out1  = out_v[0];
  assign out2  = out_v[1];
  assign rise1 = rise_v[0];
  assign rise2 = rise_v[1];
  assign fall1 = fall_v[0];
  assign fall2 = fall_v[1];
  for (genvar g = 0; g < 2; g++) begin : ch
    typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} state_t;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic s, o, r, f;
`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] sync;
    // two-flop metastability synchronizer on the raw pin
    always_ff @(posedge clk) sync <= rst ? 2'b00 : {sync[0], in_v[g]};
    assign s = sync[1];
`else
    assign s = in_v[g];
`endif
    // stability FSM: a new level is accepted after STABLE_CYCLES identical samples
    always_ff @(posedge clk) begin
      if (rst) begin
        state <= STABLE_LO;
        cnt   <= '0;
        o     <= 1'b0;
        r     <= 1'b0;
        f     <= 1'b0;
      end else begin
        r <= 1'b0;
        f <= 1'b0;
        case (state)
          STABLE_LO:
            if (s) begin
              if (ONE) begin
                state <= STABLE_HI;
                o     <= 1'b1;
                r     <= 1'b1;
              end else begin
                state <= CHK_HI;
                cnt   <= CNT_W'(1);
              end
            end
          CHK_HI:
            if (!s) begin
              state <= STABLE_LO;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state <= STABLE_HI;
              o     <= 1'b1;
              r     <= 1'b1;
              cnt   <= '0;
            end else cnt <= cnt + CNT_W'(1);
          STABLE_HI:
            if (!s) begin
              if (ONE) begin
                state <= STABLE_LO;
                o     <= 1'b0;
                f     <= 1'b1;
              end else begin
                state <= CHK_LO;
                cnt   <= CNT_W'(1);
              end
            end
          CHK_LO:
            if (s) begin
              state <= STABLE_HI;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state <= STABLE_LO;
              o     <= 1'b0;
              f     <= 1'b1;
              cnt   <= '0;
            end else cnt <= cnt + CNT_W'(1);
          default: begin
            state <= STABLE_LO;
            cnt   <= '0;
          end
        endcase
      end
    end
    assign out_v[g]  = o;
    assign rise_v[g] = r;
    assign fall_v[g] = f;
  end
endmodule
